// File: rtl/ocl_axil_pkg.sv
// Shared definitions for the OCL AXI-Lite register slice and the register core.
package ocl_axil_pkg;

  // Default AXI-Lite widths.
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  // Occupancy of one skid channel: nothing held, output register only, or
  // output register plus skid register.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  // Response codes shared with the register core.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // A channel can take a new beat unless both of its entries are occupied.
  function automatic logic skid_can_accept(input skid_state_e state);
    return (state != SKID_TWO);
  endfunction

  // A channel presents a beat whenever at least one entry is occupied.
  function automatic logic skid_has_beat(input skid_state_e state);
    return (state != SKID_EMPTY);
  endfunction

endpackage

// File: rtl/axil_skid_buf.sv
// Two-entry skid buffer for one valid/ready channel. Both in_ready_o and
// out_valid_o come straight from flops, so neither ready nor valid has a
// combinational path through this block.
module axil_skid_buf
  import ocl_axil_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             srst_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i
);

  skid_state_e      state_q;
  skid_state_e      state_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] out_data_d;
  logic [WIDTH-1:0] skid_data_q;
  logic [WIDTH-1:0] skid_data_d;
  logic             out_load_s;
  logic             skid_load_s;
  logic             accept_s;
  logic             drain_s;

  // A beat enters only against the registered ready, and leaves only while
  // the output register is presenting it.
  assign accept_s = in_valid_i & in_ready_q;
  assign drain_s  = out_valid_q & out_ready_i;

  // Next occupancy and which payload register (if any) loads this cycle.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    skid_data_d = skid_data_q;
    out_load_s  = 1'b0;
    skid_load_s = 1'b0;
    if (srst_i) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (accept_s) begin
            state_d    = SKID_ONE;
            out_load_s = 1'b1;
            out_data_d = in_data_i;
          end else begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_ONE: begin
          if (accept_s && drain_s) begin
            // Old beat leaves while the new one takes its place.
            state_d    = SKID_ONE;
            out_load_s = 1'b1;
            out_data_d = in_data_i;
          end else if (accept_s) begin
            // Output is stalled: park the new beat behind it.
            state_d     = SKID_TWO;
            skid_load_s = 1'b1;
            skid_data_d = in_data_i;
          end else if (drain_s) begin
            state_d = SKID_EMPTY;
          end else begin
            state_d = SKID_ONE;
          end
        end
        SKID_TWO: begin
          // in_ready is already low here, so nothing new can arrive.
          if (drain_s) begin
            state_d    = SKID_ONE;
            out_load_s = 1'b1;
            out_data_d = skid_data_q;
          end else begin
            state_d = SKID_TWO;
          end
        end
        default: begin
          state_d = SKID_EMPTY;
        end
      endcase
    end
  end

  // Control flops: occupancy plus registered ready/valid derived from it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= SKID_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= skid_can_accept(state_d);
      out_valid_q <= skid_has_beat(state_d);
    end
  end

  // Payload flops load only on an accepted beat or a skid-to-output move.
  always_ff @(posedge clk_i) begin
    if (out_load_s) begin
      out_data_q <= out_data_d;
    end
    if (skid_load_s) begin
      skid_data_q <= skid_data_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/ocl_axil_skid_slice.sv
// Full AXI-Lite register slice between the OCL master and the register core.
// Every channel gets its own skid buffer; nothing is decoded or altered.
module ocl_axil_skid_slice
  import ocl_axil_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                clk_main_a0,
  input  logic                rst_main_n,
  // Slave side (from the OCL master)
  input  logic                s_axi_awvalid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  output logic                s_axi_awready,
  input  logic                s_axi_wvalid,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  output logic                s_axi_wready,
  output logic                s_axi_bvalid,
  output logic [1:0]          s_axi_bresp,
  input  logic                s_axi_bready,
  input  logic                s_axi_arvalid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  output logic                s_axi_arready,
  output logic                s_axi_rvalid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  input  logic                s_axi_rready,
  // Master side (toward the register core)
  output logic                m_axi_awvalid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  input  logic                m_axi_awready,
  output logic                m_axi_wvalid,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  input  logic                m_axi_wready,
  input  logic                m_axi_bvalid,
  input  logic [1:0]          m_axi_bresp,
  output logic                m_axi_bready,
  output logic                m_axi_arvalid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  input  logic                m_axi_arready,
  input  logic                m_axi_rvalid,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  output logic                m_axi_rready
);

  localparam int unsigned W_PAY_W = DATA_W + DATA_W / 8;
  localparam int unsigned R_PAY_W = DATA_W + 2;

  logic [W_PAY_W-1:0] w_in_s;
  logic [W_PAY_W-1:0] w_out_s;
  logic [R_PAY_W-1:0] r_in_s;
  logic [R_PAY_W-1:0] r_out_s;

  // W and R carry two fields each; pack them into a single payload word.
  assign w_in_s                     = {s_axi_wdata, s_axi_wstrb};
  assign {m_axi_wdata, m_axi_wstrb} = w_out_s;
  assign r_in_s                     = {m_axi_rdata, m_axi_rresp};
  assign {s_axi_rdata, s_axi_rresp} = r_out_s;

  // Write address, master to core.
  axil_skid_buf #(.WIDTH(ADDR_W)) u_aw_buf (
    .clk_i       (clk_main_a0),
    .rst_ni      (rst_main_n),
    .srst_i      (1'b0),
    .in_valid_i  (s_axi_awvalid),
    .in_data_i   (s_axi_awaddr),
    .in_ready_o  (s_axi_awready),
    .out_valid_o (m_axi_awvalid),
    .out_data_o  (m_axi_awaddr),
    .out_ready_i (m_axi_awready)
  );

  // Write data, master to core.
  axil_skid_buf #(.WIDTH(W_PAY_W)) u_w_buf (
    .clk_i       (clk_main_a0),
    .rst_ni      (rst_main_n),
    .srst_i      (1'b0),
    .in_valid_i  (s_axi_wvalid),
    .in_data_i   (w_in_s),
    .in_ready_o  (s_axi_wready),
    .out_valid_o (m_axi_wvalid),
    .out_data_o  (w_out_s),
    .out_ready_i (m_axi_wready)
  );

  // Read address, master to core.
  axil_skid_buf #(.WIDTH(ADDR_W)) u_ar_buf (
    .clk_i       (clk_main_a0),
    .rst_ni      (rst_main_n),
    .srst_i      (1'b0),
    .in_valid_i  (s_axi_arvalid),
    .in_data_i   (s_axi_araddr),
    .in_ready_o  (s_axi_arready),
    .out_valid_o (m_axi_arvalid),
    .out_data_o  (m_axi_araddr),
    .out_ready_i (m_axi_arready)
  );

  // Write response, core back to master.
  axil_skid_buf #(.WIDTH(2)) u_b_buf (
    .clk_i       (clk_main_a0),
    .rst_ni      (rst_main_n),
    .srst_i      (1'b0),
    .in_valid_i  (m_axi_bvalid),
    .in_data_i   (m_axi_bresp),
    .in_ready_o  (m_axi_bready),
    .out_valid_o (s_axi_bvalid),
    .out_data_o  (s_axi_bresp),
    .out_ready_i (s_axi_bready)
  );

  // Read data, core back to master.
  axil_skid_buf #(.WIDTH(R_PAY_W)) u_r_buf (
    .clk_i       (clk_main_a0),
    .rst_ni      (rst_main_n),
    .srst_i      (1'b0),
    .in_valid_i  (m_axi_rvalid),
    .in_data_i   (r_in_s),
    .in_ready_o  (m_axi_rready),
    .out_valid_o (s_axi_rvalid),
    .out_data_o  (r_out_s),
    .out_ready_i (s_axi_rready)
  );

endmodule

// File: tb/tb_ocl_axil_skid_slice.sv
// Bench for ocl_axil_skid_slice: each channel is modelled as a two-deep FIFO
// (count + contents) and checked every cycle, plus directed literal checks.
module tb_ocl_axil_skid_slice;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic [3:0]  s_axi_wstrb, m_axi_wstrb;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic [1:0]  s_axi_bresp, s_axi_rresp, m_axi_bresp, m_axi_rresp;
  logic        s_axi_rvalid, s_axi_rready;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  // Channel view: 0=AW 1=W 2=AR 3=B 4=R
  logic [4:0]  iv, ordy;
  logic [63:0] idat [5];
  logic [4:0]  irdy, ov;
  logic [63:0] od [5];

  assign s_axi_awvalid = iv[0];
  assign s_axi_awaddr  = idat[0][31:0];
  assign s_axi_wvalid  = iv[1];
  assign s_axi_wdata   = idat[1][35:4];
  assign s_axi_wstrb   = idat[1][3:0];
  assign s_axi_arvalid = iv[2];
  assign s_axi_araddr  = idat[2][31:0];
  assign m_axi_bvalid  = iv[3];
  assign m_axi_bresp   = idat[3][1:0];
  assign m_axi_rvalid  = iv[4];
  assign m_axi_rdata   = idat[4][33:2];
  assign m_axi_rresp   = idat[4][1:0];
  assign m_axi_awready = ordy[0];
  assign m_axi_wready  = ordy[1];
  assign m_axi_arready = ordy[2];
  assign s_axi_bready  = ordy[3];
  assign s_axi_rready  = ordy[4];

  assign irdy = {m_axi_rready, m_axi_bready, s_axi_arready, s_axi_wready, s_axi_awready};
  assign ov   = {s_axi_rvalid, s_axi_bvalid, m_axi_arvalid, m_axi_wvalid, m_axi_awvalid};
  assign od[0] = {32'd0, m_axi_awaddr};
  assign od[1] = {28'd0, m_axi_wdata, m_axi_wstrb};
  assign od[2] = {32'd0, m_axi_araddr};
  assign od[3] = {62'd0, s_axi_bresp};
  assign od[4] = {30'd0, s_axi_rdata, s_axi_rresp};

  ocl_axil_skid_slice #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_main_a0  (clk),          .rst_main_n   (rst_n),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awaddr (s_axi_awaddr), .s_axi_awready(s_axi_awready),
    .s_axi_wvalid (s_axi_wvalid),  .s_axi_wdata  (s_axi_wdata),  .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wready (s_axi_wready),
    .s_axi_bvalid (s_axi_bvalid),  .s_axi_bresp  (s_axi_bresp),  .s_axi_bready (s_axi_bready),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_araddr (s_axi_araddr), .s_axi_arready(s_axi_arready),
    .s_axi_rvalid (s_axi_rvalid),  .s_axi_rdata  (s_axi_rdata),  .s_axi_rresp  (s_axi_rresp),
    .s_axi_rready (s_axi_rready),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr (m_axi_awaddr), .m_axi_awready(m_axi_awready),
    .m_axi_wvalid (m_axi_wvalid),  .m_axi_wdata  (m_axi_wdata),  .m_axi_wstrb  (m_axi_wstrb),
    .m_axi_wready (m_axi_wready),
    .m_axi_bvalid (m_axi_bvalid),  .m_axi_bresp  (m_axi_bresp),  .m_axi_bready (m_axi_bready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr (m_axi_araddr), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid (m_axi_rvalid),  .m_axi_rdata  (m_axi_rdata),  .m_axi_rresp  (m_axi_rresp),
    .m_axi_rready (m_axi_rready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_dlv   = 0;

  function automatic logic [63:0] ch_mask(input int c);
    case (c)
      0, 2:    return 64'h0000_0000_FFFF_FFFF;
      1:       return 64'h0000_000F_FFFF_FFFF;
      3:       return 64'h0000_0000_0000_0003;
      default: return 64'h0000_0003_FFFF_FFFF;
    endcase
  endfunction

  function automatic string ch_name(input int c);
    case (c)
      0: return "aw";
      1: return "w";
      2: return "ar";
      3: return "b";
      default: return "r";
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per channel a FIFO of at most two beats. A beat enters
  // when valid is high and the model's ready (room as of the previous edge)
  // was high; the head leaves when it is presented and downstream is ready.
  int          mcnt [5];
  logic [63:0] mbuf [5][2];
  logic [4:0]  mrdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 5; c++) mcnt[c] <= 0;
      mrdy <= 5'b0;
    end else begin
      for (int c = 0; c < 5; c++) begin
        int          n;
        logic [63:0] b0, b1;
        n  = mcnt[c];
        b0 = mbuf[c][0];
        b1 = mbuf[c][1];
        if (n > 0 && ordy[c]) begin
          b0 = b1;
          n  = n - 1;
          n_dlv <= n_dlv + 1;
        end
        if (iv[c] && mrdy[c]) begin
          if (n == 0) b0 = idat[c] & ch_mask(c);
          else        b1 = idat[c] & ch_mask(c);
          n = n + 1;
        end
        mcnt[c]    <= n;
        mbuf[c][0] <= b0;
        mbuf[c][1] <= b1;
        mrdy[c]    <= (n < 2);
      end
    end
  end

  // Per-cycle comparison of every channel against the model.
  always @(negedge clk) begin
    for (int c = 0; c < 5; c++) begin
      chk({ch_name(c), "_valid"}, {63'd0, ov[c]}, {63'd0, (mcnt[c] != 0)});
      chk({ch_name(c), "_ready"}, {63'd0, irdy[c]}, {63'd0, mrdy[c]});
      if (mcnt[c] != 0) chk({ch_name(c), "_data"}, od[c] & ch_mask(c), mbuf[c][0]);
    end
  end

  logic [31:0] got_q [$];
  logic [4:0]  rdy_seen;

  initial begin
    iv    = 5'b0;
    ordy  = 5'b0;
    for (int c = 0; c < 5; c++) idat[c] = 64'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {59'd0, irdy}, 64'd0);
    chk("rst_valid", {59'd0, ov}, 64'd0);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", {59'd0, irdy}, 64'd0);
    @(negedge clk);
    chk("ready_after_edge", {59'd0, irdy}, 64'h1F);

    // Single write then its response.
    ordy = 5'b11111;
    iv[0] = 1'b1; idat[0] = 64'h500;
    iv[1] = 1'b1; idat[1] = {28'd0, 32'hDEAD_BEEF, 4'hF};
    @(negedge clk);
    iv[1:0] = 2'b00;
    chk("wr_awvalid", {63'd0, m_axi_awvalid}, 64'd1);
    chk("wr_awaddr", {32'd0, m_axi_awaddr}, 64'h500);
    chk("wr_wvalid", {63'd0, m_axi_wvalid}, 64'd1);
    chk("wr_wdata", {32'd0, m_axi_wdata}, 64'hDEAD_BEEF);
    chk("wr_wstrb", {60'd0, m_axi_wstrb}, 64'hF);
    iv[3] = 1'b1; idat[3] = 64'd0;
    @(negedge clk);
    iv[3] = 1'b0;
    chk("b_valid", {63'd0, s_axi_bvalid}, 64'd1);
    chk("b_resp", {62'd0, s_axi_bresp}, 64'd0);
    @(negedge clk);
    chk("b_drained", {63'd0, s_axi_bvalid}, 64'd0);

    // Read-address back-pressure with three beats.
    ordy[2] = 1'b0;
    iv[2] = 1'b1; idat[2] = 64'h0;
    @(negedge clk);
    idat[2] = 64'h4;
    @(negedge clk);
    idat[2] = 64'h8;
    chk("ar_full_ready", {63'd0, s_axi_arready}, 64'd0);
    @(negedge clk);
    chk("ar_still_full", {63'd0, s_axi_arready}, 64'd0);
    chk("ar_head_held", {32'd0, m_axi_araddr}, 64'h0);
    ordy[2] = 1'b1;
    for (int k = 0; k < 20 && got_q.size() < 3; k++) begin
      logic r;
      if (m_axi_arvalid) got_q.push_back(m_axi_araddr);
      r = s_axi_arready;
      @(negedge clk);
      if (r && iv[2]) iv[2] = 1'b0;
    end
    chk("ar_count", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      chk("ar_beat0", {32'd0, got_q[0]}, 64'h0);
      chk("ar_beat1", {32'd0, got_q[1]}, 64'h4);
      chk("ar_beat2", {32'd0, got_q[2]}, 64'h8);
    end
    chk("ar_no_dup", {63'd0, m_axi_arvalid}, 64'd0);

    // Streaming 16 read beats at full rate.
    for (int k = 0; k <= 16; k++) begin
      iv[4]   = (k < 16);
      idat[4] = {30'd0, 32'(k), 2'b00};
      @(negedge clk);
      if (k < 16) begin
        chk("r_stream_valid", {63'd0, s_axi_rvalid}, 64'd1);
        chk("r_stream_data", {32'd0, s_axi_rdata}, 64'(k));
      end else begin
        chk("r_stream_idle", {63'd0, s_axi_rvalid}, 64'd0);
      end
    end
    iv[4] = 1'b0;

    // Stalled write data must hold steady.
    ordy[1] = 1'b0;
    iv[1] = 1'b1; idat[1] = {28'd0, 32'h1234_5678, 4'h3};
    @(negedge clk);
    iv[1] = 1'b0;
    repeat (5) begin
      chk("w_stall_valid", {63'd0, m_axi_wvalid}, 64'd1);
      chk("w_stall_data", {32'd0, m_axi_wdata}, 64'h1234_5678);
      @(negedge clk);
    end
    ordy[1] = 1'b1;
    @(negedge clk);
    chk("w_released", {63'd0, m_axi_wvalid}, 64'd0);

    // Reset with AW full.
    ordy[0] = 1'b0;
    iv[0] = 1'b1; idat[0] = 64'h100;
    @(negedge clk);
    idat[0] = 64'h104;
    @(negedge clk);
    iv[0] = 1'b0;
    chk("aw_full", {63'd0, s_axi_awready}, 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {59'd0, ov}, 64'd0);
    chk("midrst_ready", {59'd0, irdy}, 64'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    ordy[0] = 1'b1;
    #1 chk("rel_ready_low", {59'd0, irdy}, 64'd0);
    @(negedge clk);
    chk("rel_ready_high", {59'd0, irdy}, 64'h1F);
    chk("rel_no_stale", {59'd0, ov}, 64'd0);

    // Random valid/ready traffic on all channels.
    n_dlv    = 0;
    rdy_seen = irdy;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int c = 0; c < 5; c++) begin
        if (!(iv[c] && !rdy_seen[c])) begin
          iv[c]   = ($urandom_range(0, 99) < 65);
          idat[c] = {$urandom, $urandom} & ch_mask(c);
        end
        ordy[c] = ($urandom_range(0, 99) < 60);
      end
      rdy_seen = irdy;
      @(negedge clk);
    end
    iv = 5'b0;
    chk("random_traffic", {63'd0, (n_dlv > 1000)}, 64'd1);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ocl_axil_skid_slice.md
OCL_AXIL_SKID_SLICE -- requirements
Module: ocl_axil_skid_slice

Interface
REQ-001 Parameters: ADDR_W, 32, AXI-Lite address width on the AW and AR channels.
REQ-002 Parameters: DATA_W, 32, AXI-Lite data width on the W and R channels. WSTRB width is DATA_W/8.
REQ-003 Ports: clk_main_a0  in  1  sole clock; all logic is rising-edge.
REQ-004 Ports: rst_main_n  in  1  reset, asynchronous assert, active-low.
REQ-005 Ports: s_axi_awvalid/awaddr  in  1/ADDR_W; s_axi_awready  out  1  (slave-side write address).
REQ-006 Ports: s_axi_wvalid/wdata/wstrb  in  1/DATA_W/DATA_W/8; s_axi_wready  out  1  (slave-side write data).
REQ-007 Ports: s_axi_bvalid/bresp  out  1/2; s_axi_bready  in  1  (slave-side write response).
REQ-008 Ports: s_axi_arvalid/araddr  in  1/ADDR_W; s_axi_arready  out  1  (slave-side read address).
REQ-009 Ports: s_axi_rvalid/rdata/rresp  out  1/DATA_W/2; s_axi_rready  in  1  (slave-side read data).
REQ-010 Ports: m_axi_* form the mirror set of all five channels toward the register core, with the same widths and opposite directions.

Function
REQ-011 Each channel SHALL be an independent two-entry skid buffer: an output register plus one skid register.
- Forward channels are AW, W and AR (s to m).
- Reverse channels are B and R (m to s).
REQ-012 Each channel has three states:
- EMPTY: out_valid=0, in_ready=1.
- ONE: out_valid=1, in_ready=1.
- TWO: out_valid=1, in_ready=0.
REQ-013 State transitions:
- EMPTY->ONE on in_valid.
- ONE->EMPTY on out_ready && !in_valid.
- ONE->TWO on in_valid && !out_ready.
- ONE holds on in_valid && out_ready.
- TWO->ONE on out_ready, with the skid entry moving to the output register.
REQ-014 in_ready SHALL be a flop output. There SHALL be no combinational path from any ready input to any ready output, or from any valid input to any valid output.
REQ-015 Latency SHALL be exactly 1 cycle from an accepted input beat to out_valid.
REQ-016 Throughput SHALL be one beat per cycle when the downstream ready is held high.
REQ-017 Beats on each channel SHALL emerge in acceptance order with payload bit-exact. Channels are not reordered relative to themselves.
REQ-018 Once out_valid is asserted, out_valid and the payload SHALL stay stable until out_ready is sampled high (AXI rule).
REQ-019 In TWO, a simultaneous out_ready and in_valid SHALL NOT accept the input, because in_ready=0 is already registered.
REQ-020 Payload registers SHALL load only on an accepted beat. There is no data reset on payload, to save area.
REQ-021 The block SHALL NOT decode, check or modify addresses, strobes or responses.

Reset
REQ-022 While rst_main_n=0, all state flops SHALL be EMPTY and every valid output and every ready output SHALL be 0.
REQ-023 Ready outputs SHALL rise on the first clk_main_a0 edge after rst_main_n deasserts.
REQ-024 Reset asserted mid-transfer SHALL discard all buffered beats immediately (asynchronous). Payload outputs are don't-care while valid=0.

Structure
REQ-025 Package ocl_axil_pkg SHALL hold:
- the ADDR_W and DATA_W defaults;
- the skid state enum (EMPTY, ONE, TWO);
- the RESP_OKAY/RESP_SLVERR constants shared with the register core.
REQ-026 One sub-module, axil_skid_buf, SHALL be parameterised by payload width and instantiated five times: AW, W, AR, B and R.

Verification
REQ-027 Single write: AW addr 0x0000_0500 and W 0xDEAD_BEEF/strb 0xF, m_axi ready high.
- m_axi_awvalid and m_axi_wvalid are seen 1 cycle later with identical payload.
- B 2'b00 returns to s_axi_bvalid 1 cycle after m_axi_bvalid.
REQ-028 Back-pressure: push 3 AR beats (0x0, 0x4, 0x8) with m_axi_arready=0.
- Beats 1 and 2 are accepted.
- s_axi_arready drops to 0 the cycle after the second accept.
- On releasing ready, the 3 addresses appear in order with no loss or duplication.
REQ-029 Streaming: 16 consecutive R beats 0x0..0xF with both readies high.
- One beat per cycle.
- Output lags input by exactly 1 cycle.
REQ-030 Stability: hold m_axi_wready=0 for 5 cycles with W buffered.
- m_axi_wvalid stays 1 throughout.
- m_axi_wdata stays constant throughout.
REQ-031 Reset mid-operation: assert rst_main_n=0 with both entries of AW full.
- All valid and ready outputs read 0 within the same cycle.
- After release, no stale beat emerges.
- s_axi_awready=1 one edge later.
REQ-032 Random stall: random valid/ready toggling on all five channels for 10k cycles.
- The scoreboard sees in-order, bit-exact delivery.
- Assertions for REQ-014 and REQ-018 never fire.
